// File: rtl/ram_arbiter.sv
// ram_arbiter
// -----------------------------------------------------------------------------
// Two-requester arbiter in front of a single-port asynchronous-read RAM.
// Each access takes three cycles: IDLE (sample and latch the request),
// ACCESS (drive the RAM), DONE (ack pulse to the winner). Ties are broken
// round-robin using the identity of the last requester granted.
//
// Ports
//   clk, reset                    single clock, synchronous active-high reset
//   r0_req/r1_req                 access request, held until ack
//   r0_we/r1_we                   1 = write, 0 = read
//   r0_addr/r1_addr               access address
//   r0_wdata/r1_wdata             write data
//   r0_ack/r1_ack                 one-cycle completion pulse (DONE state)
//   r0_rdata/r1_rdata             registered read data per requester
//   ram_addr, ram_wdata           RAM address / write data (latched values)
//   ram_rdata                     RAM read data, combinational from the RAM
//   ram_cs_n, ram_we_n, ram_oe_n  active-low RAM controls, asserted in ACCESS
//   busy                          high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module ram_arbiter #(
    parameter int AddressSize = 16,
    parameter int WordSize    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   r0_req,
    input  logic                   r1_req,
    input  logic                   r0_we,
    input  logic                   r1_we,
    input  logic [AddressSize-1:0] r0_addr,
    input  logic [AddressSize-1:0] r1_addr,
    input  logic [WordSize-1:0]    r0_wdata,
    input  logic [WordSize-1:0]    r1_wdata,
    output logic                   r0_ack,
    output logic                   r1_ack,
    output logic [WordSize-1:0]    r0_rdata,
    output logic [WordSize-1:0]    r1_rdata,
    output logic [AddressSize-1:0] ram_addr,
    output logic [WordSize-1:0]    ram_wdata,
    input  logic [WordSize-1:0]    ram_rdata,
    output logic                   ram_cs_n,
    output logic                   ram_we_n,
    output logic                   ram_oe_n,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   grant_q, grant_d;      // 0 = r0, 1 = r1
    logic                   last_grant_q, last_grant_d;
    logic                   we_q, we_d;
    logic [AddressSize-1:0] addr_q, addr_d;
    logic [WordSize-1:0]    wdata_q, wdata_d;

    // Requester inputs gathered into arrays so per-requester logic can be
    // generated uniformly.
    logic [1:0]             req_in;
    logic [1:0]             we_in;
    logic [AddressSize-1:0] addr_in  [2];
    logic [WordSize-1:0]    wdata_in [2];
    logic [WordSize-1:0]    rdata_q  [2];
    logic [1:0]             ack;

    logic                   in_access;
    logic                   winner;

    assign req_in      = {r1_req, r0_req};
    assign we_in       = {r1_we, r0_we};
    assign addr_in[0]  = r0_addr;
    assign addr_in[1]  = r1_addr;
    assign wdata_in[0] = r0_wdata;
    assign wdata_in[1] = r1_wdata;

    // Sole requester wins; on a tie the one not granted last time wins.
    always_comb begin
        winner = 1'b0;
        if (req_in == 2'b11) begin
            winner = ~last_grant_q;
        end else begin
            winner = req_in[1];
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (|req_in) begin
                    state_d      = S_ACCESS;
                    grant_d      = winner;
                    last_grant_d = winner;
                    we_d         = we_in[winner];
                    addr_d       = addr_in[winner];
                    wdata_d      = wdata_in[winner];
                end
            end
            S_ACCESS: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;   // r0 wins the first tie after reset
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // RAM controls decode straight from the state register, so a write in
    // ACCESS still commits at the edge where reset is sampled.
    assign in_access = (state_q == S_ACCESS);
    assign ram_cs_n  = ~in_access;
    assign ram_we_n  = ~(in_access & we_q);
    assign ram_oe_n  = ~(in_access & ~we_q);
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign busy      = (state_q != S_IDLE);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign ack[gi] = (state_q == S_DONE) && (grant_q == 1'(gi));

            // Capture read data at the edge ending ACCESS; writes leave it alone.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_q[gi] <= '0;
                end else if (in_access && !we_q && (grant_q == 1'(gi))) begin
                    rdata_q[gi] <= ram_rdata;
                end
            end
        end
    endgenerate

    assign r0_ack   = ack[0];
    assign r1_ack   = ack[1];
    assign r0_rdata = rdata_q[0];
    assign r1_rdata = rdata_q[1];

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed testbench for ram_arbiter with a behavioural asynchronous-read RAM.
module tb_ram_arbiter;

    logic        clk;
    logic        reset;
    logic        r0_req, r1_req, r0_we, r1_we;
    logic [15:0] r0_addr, r1_addr;
    logic [7:0]  r0_wdata, r1_wdata;
    logic        r0_ack, r1_ack;
    logic [7:0]  r0_rdata, r1_rdata;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;
    logic        ram_cs_n, ram_we_n, ram_oe_n, busy;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_rd [2];

    ram_arbiter #(.AddressSize(16), .WordSize(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .r0_req    (r0_req),
        .r1_req    (r1_req),
        .r0_we     (r0_we),
        .r1_we     (r1_we),
        .r0_addr   (r0_addr),
        .r1_addr   (r1_addr),
        .r0_wdata  (r0_wdata),
        .r1_wdata  (r1_wdata),
        .r0_ack    (r0_ack),
        .r1_ack    (r1_ack),
        .r0_rdata  (r0_rdata),
        .r1_rdata  (r1_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_cs_n  (ram_cs_n),
        .ram_we_n  (ram_we_n),
        .ram_oe_n  (ram_oe_n),
        .busy      (busy)
    );

    // RAM model: asynchronous read, write on rising edge, not reset.
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (!ram_cs_n && !ram_we_n) mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int rid, input logic req, input logic we,
                         input logic [15:0] addr, input logic [7:0] data);
        if (rid == 0) begin
            r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = data;
        end else begin
            r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = data;
        end
    endtask

    // Control-line invariants on every falling edge.
    always @(negedge clk) begin
        check("we_oe_excl", {31'd0, ram_we_n | ram_oe_n}, 32'd1);
        check("ctl_idle", {31'd0, ram_cs_n ? (ram_we_n & ram_oe_n) : 1'b1}, 32'd1);
        check("ack_excl", {31'd0, r0_ack & r1_ack}, 32'd0);
        check("cs_busy", {31'd0, ram_cs_n | busy}, 32'd1);
    end

    // Full single access from IDLE; requester inputs are scrambled right
    // after the grant to confirm the latched values are the ones used.
    task automatic do_access(input int rid, input logic we, input logic [15:0] addr,
                             input logic [7:0] data, input logic [7:0] exp_data);
        logic [7:0] got_rd;
        drive(rid, 1'b1, we, addr, data);
        tick();
        check("acc_cs", {31'd0, ram_cs_n}, 32'd0);
        check("acc_we", {31'd0, ram_we_n}, {31'd0, ~we});
        check("acc_oe", {31'd0, ram_oe_n}, {31'd0, we});
        check("acc_addr", {16'd0, ram_addr}, {16'd0, addr});
        if (we) check("acc_wdata", {24'd0, ram_wdata}, {24'd0, data});
        check("acc_noack", {30'd0, r1_ack, r0_ack}, 32'd0);
        drive(rid, 1'b0, ~we, ~addr, ~data);
        tick();
        check("done_ack", {30'd0, r1_ack, r0_ack}, (rid == 0) ? 32'd1 : 32'd2);
        check("done_ctl", {29'd0, ram_cs_n, ram_we_n, ram_oe_n}, 32'd7);
        check("done_busy", {31'd0, busy}, 32'd1);
        if (!we) exp_rd[rid] = exp_data;
        got_rd = (rid == 0) ? r0_rdata : r1_rdata;
        check("done_rdata", {24'd0, got_rd}, {24'd0, exp_rd[rid]});
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_ack", {30'd0, r1_ack, r0_ack}, 32'd0);
        $display("access r%0d %s addr=0x%04h wdata=0x%02h rdata=0x%02h", rid,
                 we ? "WR" : "RD", addr, data, got_rd);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0, 8'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 8'h0);
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ack", {30'd0, r1_ack, r0_ack}, 32'd0);
        check("rst_ctl", {29'd0, ram_cs_n, ram_we_n, ram_oe_n}, 32'd7);
        check("rst_rdata", {16'd0, r1_rdata, r0_rdata}, 32'd0);
        reset = 1'b0;
        tick();

        // Write then read back through r0.
        do_access(0, 1'b1, 16'h1234, 8'hA5, 8'h00);
        check("scramble_untouched", {24'd0, mem[16'hEDCB]} , {24'd0, 8'hxx} === 32'hx ? 32'd0 : {24'd0, mem[16'hEDCB]});
        do_access(0, 1'b0, 16'h1234, 8'h00, 8'hA5);

        // Preload for the tie tests.
        do_access(0, 1'b1, 16'h0100, 8'h11, 8'h00);
        do_access(1, 1'b1, 16'h0200, 8'h22, 8'h00);

        // Tie after reset: r0, then r1, then r0 with both held high.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        drive(0, 1'b1, 1'b0, 16'h0100, 8'h00);
        drive(1, 1'b1, 1'b0, 16'h0200, 8'h00);
        tick();
        check("tie1_addr", {16'd0, ram_addr}, 32'h0100);
        tick();
        check("tie1_ack", {30'd0, r1_ack, r0_ack}, 32'd1);
        check("tie1_rdata", {24'd0, r0_rdata}, 32'h11);
        tick();
        check("tie1_idle", {31'd0, busy}, 32'd0);
        tick();
        check("tie2_addr", {16'd0, ram_addr}, 32'h0200);
        tick();
        check("tie2_ack", {30'd0, r1_ack, r0_ack}, 32'd2);
        check("tie2_rdata", {24'd0, r1_rdata}, 32'h22);
        tick();
        tick();
        check("tie3_addr", {16'd0, ram_addr}, 32'h0100);
        drive(1, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        check("tie3_ack", {30'd0, r1_ack, r0_ack}, 32'd1);
        drive(0, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        $display("tie sequence r0 -> r1 -> r0 done");

        // r1 streaming: ack on every third cycle.
        drive(1, 1'b1, 1'b0, 16'h0200, 8'h00);
        for (int k = 1; k <= 9; k++) begin
            tick();
            check("stream_ack", {30'd0, r1_ack, r0_ack}, (k % 3 == 2) ? 32'd2 : 32'd0);
        end
        drive(1, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        check("stream_end_busy", {31'd0, busy}, 32'd0);
        $display("stream r1 x3 done");

        // Reset during a write ACCESS: write lands, no ack.
        drive(0, 1'b1, 1'b1, 16'h0010, 8'h3C);
        tick();
        check("rstw_we", {31'd0, ram_we_n}, 32'd0);
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        check("rstw_ack", {30'd0, r1_ack, r0_ack}, 32'd0);
        check("rstw_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        tick();
        check("rstw_ack2", {30'd0, r1_ack, r0_ack}, 32'd0);
        do_access(0, 1'b0, 16'h0010, 8'h00, 8'h3C);

        // Reset during a read ACCESS leaves rdata at 0.
        drive(0, 1'b1, 1'b0, 16'h1234, 8'h00);
        tick();
        check("rstr_oe", {31'd0, ram_oe_n}, 32'd0);
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        reset = 1'b0;
        check("rstr_rdata", {24'd0, r0_rdata}, 32'd0);
        check("rstr_ack", {30'd0, r1_ack, r0_ack}, 32'd0);
        tick();
        check("rstr_ack2", {30'd0, r1_ack, r0_ack}, 32'd0);
        $display("reset-interrupted accesses done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
